demux_rr_sched: RTL and testbench

Round-robin dispatch scheduler for the 1-to-4 demux datapath. It accepts a single valid/ready input stream, buffers one word and selects a destination channel among four. It drives the 2-bit select and a one-hot valid toward the channels, and holds each word until the selected channel accepts it. It sits between a single producer and four consumer lanes and replaces hard-wired select logic.

---
 rtl/demux_rr_sched.sv | 99 +++++++++
 tb/tb_demux_rr_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_sched.sv
// demux_rr_sched
// Round-robin dispatch scheduler for a 1-to-4 demux datapath. It buffers one
// word from a valid/ready producer and steers it to one of four consumer lanes.
// The word stays held until the selected lane accepts it.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   ch_en        per-channel eligibility for new assignments
//   in_valid/in_data/in_ready   producer handshake
//   sel          channel index of the held word
//   out_valid    one-hot valid (bit sel while a word is held)
//   out_data     held word, shared by all channels
//   out_ready    per-channel accept
//   count        delivered-word counter (wraps)
module demux_rr_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       ch_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [1:0]       sel,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] count
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fire;
    logic             capture;
    logic             have_tgt;
    logic [1:0]       ptr_n;
    logic [1:0]       tgt;

    assign fire     = full_q & out_ready[sel_q];
    // A delivery moves the search origin past the lane just served, so a
    // word captured in the same cycle already sees the advanced pointer.
    assign ptr_n    = fire ? sel_q + 2'd1 : ptr_q;
    assign have_tgt = |ch_en;
    assign in_ready = have_tgt & (~full_q | fire);
    assign capture  = in_valid & in_ready;

    // First enabled channel at or after ptr_n; scanning from the far end
    // lets the nearest hit win without an early exit.
    always_comb begin
        tgt = ptr_n;
        for (int i = 3; i >= 0; i--) begin
            if (ch_en[ptr_n + 2'(i)]) tgt = ptr_n + 2'(i);
        end
    end

    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_n;
        count_d = count_q;
        if (fire) begin
            count_d = count_q + CNT_W'(1);
            full_d  = 1'b0;
        end
        if (capture) begin
            full_d = 1'b1;
            data_d = in_data;
            sel_d  = tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            count_q <= '0;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign out_valid = full_q ? (4'b0001 << sel_q) : 4'b0000;
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign count     = count_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: a queue/arithmetic reference model checked against
// the DUT every cycle, plus directed scenarios with literal expectations.
module tb_demux_rr_sched;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       ch_en = 4'b1111;
    logic             in_valid = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic [1:0]       sel;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_ready = 4'b1111;
    logic [CNT_W-1:0] count;

    demux_rr_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: holds at most one word, a 0..3 pointer and a counter.
    int m_full = 0, m_sel = 0, m_data = 0, m_ptr = 0, m_cnt = 0;
    bit started = 0;

    function automatic int find_tgt(input int p, input logic [3:0] en);
        for (int i = 0; i < 4; i++)
            if (en[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        int p, t;
        bit f, acc;
        started = 1;
        if (!rst_n) begin
            m_full = 0; m_sel = 0; m_data = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            f   = (m_full != 0) && out_ready[m_sel];
            p   = f ? (m_sel + 1) % 4 : m_ptr;
            t   = find_tgt(p, ch_en);
            acc = in_valid && (t >= 0) && (!m_full || f);
            if (f) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (acc) begin
                m_full = 1; m_sel = t; m_data = int'(in_data);
            end else if (f) begin
                m_full = 0;
            end
            m_ptr = p;
        end
    end

    // Deliveries seen at the DUT boundary, for the directed scenarios.
    int fire_ch[$];
    int fire_dat[$];

    always @(negedge clk) begin
        bit f;
        if (started) begin
            f = (m_full != 0) && out_ready[m_sel];
            chk("out_valid", 32'(out_valid), m_full ? 32'(4'b0001 << m_sel) : 32'd0);
            chk("in_ready", 32'(in_ready), 32'((ch_en != 0) && (!m_full || f)));
            chk("sel", 32'(sel), 32'(m_sel));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("count", 32'(count), 32'(m_cnt));
            if (rst_n && ((out_valid & out_ready) != 4'b0000)) begin
                fire_ch.push_back(int'(sel));
                fire_dat.push_back(int'(out_data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, c0;
        // 1: reset with in_valid high, then full-rate stream on all channels
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        n0 = fire_ch.size();
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            in_valid = 1'b1;
            #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            chk("t1_ch", 32'(fire_ch[n0 + k]), 32'(k % 4));
            chk("t1_dat", 32'(fire_dat[n0 + k]), 32'(8'hA0 + k));
        end
        chk("t1_count", 32'(count), 32'd5);
        chk("t1_model_count", 32'(m_cnt), 32'd5);

        // 2: only channels 1 and 3 eligible
        ch_en = 4'b1010;
        n0 = fire_ch.size();
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hB0 + 8'(i); in_valid = 1'b1; step();
        end
        in_valid = 1'b0;
        step(); step();
        for (int k = 0; k < 4; k++)
            chk("t2_ch", 32'(fire_ch[n0 + k]), (k % 2 == 0) ? 32'd1 : 32'd3);

        // 3: stall on channel 2, then release with a word already waiting
        ch_en = 4'b0100; out_ready = 4'b1011;
        in_data = 8'h55; in_valid = 1'b1;
        step();
        ch_en = 4'b1111; in_data = 8'h66;
        c0 = int'(count);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_out_valid", 32'(out_valid), 32'h4);
            chk("t3_out_data", 32'(out_data), 32'h55);
            chk("t3_in_ready", 32'(in_ready), 32'd0);
            chk("t3_count", 32'(count), 32'(c0));
            step();
        end
        out_ready = 4'b1111;
        step();
        chk("t3_count_inc", 32'(count), 32'((c0 + 1) % 16));
        chk("t3_next_sel", 32'(sel), 32'd3);
        chk("t3_next_data", 32'(out_data), 32'h66);
        in_valid = 1'b0;
        step();

        // 4: all channels disabled while a word is held on channel 1
        ch_en = 4'b0010; out_ready = 4'b0000;
        in_data = 8'h77; in_valid = 1'b1;
        step();
        chk("t4_held_sel", 32'(sel), 32'd1);
        ch_en = 4'b0000; in_data = 8'h78;
        step();
        out_ready = 4'b0010;
        #1 chk("t4_in_ready_dis", 32'(in_ready), 32'd0);
        n0 = fire_ch.size();
        step();
        chk("t4_drain_ch", 32'(fire_ch[n0]), 32'd1);
        chk("t4_drain_dat", 32'(fire_dat[n0]), 32'h77);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("t4_out_valid2", 32'(out_valid), 32'd0);
        ch_en = 4'b0001;
        #1 chk("t4_in_ready_en", 32'(in_ready), 32'd1);
        step();
        chk("t4_sel0", 32'(sel), 32'd0);
        chk("t4_dat", 32'(out_data), 32'h78);
        in_valid = 1'b0; out_ready = 4'b1111;
        step();

        // 5: counter wrap at 4 bits
        rst_n = 1'b0; step(); rst_n = 1'b1;
        ch_en = 4'b1111; out_ready = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            step();
            if (i >= 14) chk("t5_count", 32'(count), 32'(i % 16));
        end
        in_valid = 1'b0;
        step();
        chk("t5_count_final", 32'(count), 32'd1);

        // 6: reset while holding a word on channel 2 with its ready high
        ch_en = 4'b0100; out_ready = 4'b0000;
        in_data = 8'h99; in_valid = 1'b1;
        step();
        chk("t6_held_sel", 32'(sel), 32'd2);
        in_valid = 1'b0; rst_n = 1'b0; out_ready = 4'b1111;
        step();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_sel", 32'(sel), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_model_count", 32'(m_cnt), 32'd0);
        rst_n = 1'b1; ch_en = 4'b1111;
        in_data = 8'hAB; in_valid = 1'b1;
        step();
        chk("t6_next_sel", 32'(sel), 32'd0);
        chk("t6_next_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();

        // Random traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            ch_en     = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0; else rst_n = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
